// File: rtl/mac_rx_parser.sv
// Byte-wide GMII receive parser: strips preamble/SFD, filters on DA, decodes one optional
// 802.1Q tag, streams the payload minus FCS and reports CRC/length/PHY status per frame.
module mac_rx_parser #(
    parameter logic [47:0] MAC_ADDR     = 48'h0,
    parameter bit          PROMISC      = 1'b0,
    parameter bit          ACCEPT_BCAST = 1'b1,
    parameter bit          VLAN_EN      = 1'b1,
    parameter bit          PASS_UNKNOWN = 1'b0,
    parameter int unsigned MIN_FRAME    = 64,
    parameter int unsigned MAX_FRAME    = 1518
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    output logic        hdr_valid,
    output logic [47:0] sa,
    output logic [15:0] ether_type,
    output logic        vlan_valid,
    output logic [11:0] vlan_id,
    output logic        is_ipv4,
    output logic        is_arp,
    output logic        is_llc,
    output logic        frame_done,
    output logic        frame_good,
    output logic        err_crc,
    output logic        err_len,
    output logic        err_phy,
    output logic        busy
);
    typedef enum logic [2:0] {
        StIdle, StPreamble, StDest, StSource, StType, StVlan, StPayload, StDrop
    } state_e;

    localparam int unsigned FifoDepth  = 5;
    localparam logic [2:0]  FullCnt    = 3'd5;
    localparam logic [31:0] CrcResidue = 32'h2144DF1C;
    localparam logic [15:0] MinLen     = 16'(MIN_FRAME);
    localparam logic [16:0] MaxUntag   = 17'(MAX_FRAME);

    // Reflected CRC-32 (poly 0x04C11DB7), one byte LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        active_q, active_d;
    logic [47:0] da_q, da_d, sa_sh_q, sa_sh_d;
    logic [7:0]  type_hi_q, type_hi_d;
    logic        tagged_q, tagged_d;
    logic [11:0] vid_q, vid_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d;
    logic        len_bad_q, len_bad_d, phy_bad_q, phy_bad_d;
    logic [7:0]  fifo_q [FifoDepth];
    logic [7:0]  fifo_d [FifoDepth];
    logic [2:0]  fifo_cnt_q, fifo_cnt_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d, m_last_q, m_last_d, hdr_valid_q, hdr_valid_d;
    logic [47:0] sa_q, sa_d;
    logic [15:0] ether_type_q, ether_type_d;
    logic        vlan_valid_q, vlan_valid_d;
    logic [11:0] vlan_id_q, vlan_id_d;
    logic        is_ipv4_q, is_ipv4_d, is_arp_q, is_arp_d, is_llc_q, is_llc_d;
    logic        frame_done_q, frame_done_d, frame_good_q, frame_good_d;
    logic        err_crc_q, err_crc_d, err_len_q, err_len_d, err_phy_q, err_phy_d;
    logic        busy_q;
    logic [15:0] full_type;
    logic [16:0] max_len;
    logic        len_err, crc_err;

    always_comb begin
        state_d = state_q;   cnt_d = cnt_q;           active_d = active_q;
        da_d = da_q;         sa_sh_d = sa_sh_q;       type_hi_d = type_hi_q;
        tagged_d = tagged_q; vid_d = vid_q;           byte_cnt_d = byte_cnt_q;
        crc_d = crc_q;       len_bad_d = len_bad_q;   phy_bad_d = phy_bad_q;
        fifo_d = fifo_q;     fifo_cnt_d = fifo_cnt_q; m_data_d = m_data_q;
        m_valid_d = 1'b0;    m_last_d = 1'b0;         hdr_valid_d = 1'b0;
        sa_d = sa_q;         ether_type_d = ether_type_q;
        vlan_valid_d = vlan_valid_q;                  vlan_id_d = vlan_id_q;
        is_ipv4_d = is_ipv4_q; is_arp_d = is_arp_q;   is_llc_d = is_llc_q;
        frame_done_d = 1'b0; frame_good_d = 1'b0;
        err_crc_d = 1'b0;    err_len_d = 1'b0;        err_phy_d = 1'b0;
        len_err = 1'b0;      crc_err = 1'b0;
        full_type = {type_hi_q, rxd};
        max_len = tagged_q ? MaxUntag + 17'd4 : MaxUntag;

        if (!rx_dv) begin
            state_d = StIdle;
            // Status is only owed for frames that got past SFD and the address filter.
            if (active_q) begin
                active_d = 1'b0;
                len_err  = len_bad_q || (byte_cnt_q < MinLen);
                if (state_q == StPayload) begin
                    if (fifo_cnt_q == FullCnt) begin
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b1;
                        m_data_d  = fifo_q[0];
                    end else begin
                        len_err = 1'b1;
                    end
                end
                crc_err      = (~crc_q != CrcResidue);
                frame_done_d = 1'b1;
                err_crc_d    = crc_err;
                err_len_d    = len_err;
                err_phy_d    = phy_bad_q;
                frame_good_d = ~(crc_err | len_err | phy_bad_q);
            end
        end else begin
            if (active_q) begin
                byte_cnt_d = (&byte_cnt_q) ? byte_cnt_q : byte_cnt_q + 16'd1;
                crc_d      = crc32_byte(crc_q, rxd);
            end
            if (active_q && rx_er) begin
                phy_bad_d = 1'b1;
                state_d   = StDrop;
            end else begin
                case (state_q)
                    StIdle: if (rxd == 8'h55) state_d = StPreamble;
                    StPreamble: begin
                        if (rxd == 8'hD5) begin
                            state_d    = StDest;
                            active_d   = 1'b1;
                            cnt_d      = 3'd0;
                            byte_cnt_d = 16'd0;
                            crc_d      = 32'hFFFFFFFF;
                            len_bad_d  = 1'b0;
                            phy_bad_d  = 1'b0;
                            fifo_cnt_d = 3'd0;
                            tagged_d   = 1'b0;
                            vid_d      = 12'd0;
                        end else if (rxd != 8'h55) begin
                            state_d = StDrop;
                        end
                    end
                    StDest: begin
                        da_d  = {da_q[39:0], rxd};
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd5) begin
                            cnt_d = 3'd0;
                            if (da_d == MAC_ADDR || (ACCEPT_BCAST && (&da_d)) || PROMISC) begin
                                state_d = StSource;
                            end else begin
                                state_d  = StDrop;
                                active_d = 1'b0;
                            end
                        end
                    end
                    StSource: begin
                        sa_sh_d = {sa_sh_q[39:0], rxd};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd5) begin
                            cnt_d   = 3'd0;
                            state_d = StType;
                        end
                    end
                    StType: begin
                        if (cnt_q == 3'd0) begin
                            type_hi_d = rxd;
                            cnt_d     = 3'd1;
                        end else if (VLAN_EN && !tagged_q && full_type == 16'h8100) begin
                            cnt_d    = 3'd0;
                            tagged_d = 1'b1;
                            state_d  = StVlan;
                        end else begin
                            cnt_d        = 3'd0;
                            hdr_valid_d  = 1'b1;
                            sa_d         = sa_sh_q;
                            ether_type_d = full_type;
                            vlan_valid_d = tagged_q;
                            vlan_id_d    = vid_q;
                            is_ipv4_d    = (full_type == 16'h0800);
                            is_arp_d     = (full_type == 16'h0806);
                            is_llc_d     = (full_type <= 16'd1500);
                            if (full_type <= 16'd1500 || full_type == 16'h0800 ||
                                full_type == 16'h0806 ||
                                (PASS_UNKNOWN && full_type > 16'h0600)) begin
                                state_d = StPayload;
                            end else begin
                                // Rejected type still reports; flag it as a bad frame.
                                len_bad_d = 1'b1;
                                state_d   = StDrop;
                            end
                        end
                    end
                    StVlan: begin
                        if (cnt_q == 3'd0) begin
                            type_hi_d = rxd;
                            cnt_d     = 3'd1;
                        end else begin
                            vid_d   = {type_hi_q[3:0], rxd};
                            cnt_d   = 3'd0;
                            state_d = StType;
                        end
                    end
                    StPayload: begin
                        if ({1'b0, byte_cnt_q} + 17'd1 > max_len) begin
                            len_bad_d = 1'b1;
                            state_d   = StDrop;
                        end else if (fifo_cnt_q == FullCnt) begin
                            m_valid_d = 1'b1;
                            m_data_d  = fifo_q[0];
                            for (int i = 0; i < FifoDepth - 1; i++) fifo_d[i] = fifo_q[i+1];
                            fifo_d[FifoDepth-1] = rxd;
                        end else begin
                            fifo_d[fifo_cnt_q] = rxd;
                            fifo_cnt_d         = fifo_cnt_q + 3'd1;
                        end
                    end
                    StDrop: ;
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;  cnt_q <= '0;      active_q <= 1'b0;
            da_q <= '0;         sa_sh_q <= '0;    type_hi_q <= '0;
            tagged_q <= 1'b0;   vid_q <= '0;      byte_cnt_q <= '0;
            crc_q <= '1;        len_bad_q <= 1'b0; phy_bad_q <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) fifo_q[i] <= '0;
            fifo_cnt_q <= '0;   m_data_q <= '0;   m_valid_q <= 1'b0;
            m_last_q <= 1'b0;   hdr_valid_q <= 1'b0; sa_q <= '0;
            ether_type_q <= '0; vlan_valid_q <= 1'b0; vlan_id_q <= '0;
            is_ipv4_q <= 1'b0;  is_arp_q <= 1'b0; is_llc_q <= 1'b0;
            frame_done_q <= 1'b0; frame_good_q <= 1'b0;
            err_crc_q <= 1'b0;  err_len_q <= 1'b0; err_phy_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;      active_q <= active_d;
            da_q <= da_d;        sa_sh_q <= sa_sh_d;  type_hi_q <= type_hi_d;
            tagged_q <= tagged_d; vid_q <= vid_d;     byte_cnt_q <= byte_cnt_d;
            crc_q <= crc_d;      len_bad_q <= len_bad_d; phy_bad_q <= phy_bad_d;
            fifo_q <= fifo_d;    fifo_cnt_q <= fifo_cnt_d; m_data_q <= m_data_d;
            m_valid_q <= m_valid_d; m_last_q <= m_last_d; hdr_valid_q <= hdr_valid_d;
            sa_q <= sa_d;        ether_type_q <= ether_type_d;
            vlan_valid_q <= vlan_valid_d; vlan_id_q <= vlan_id_d;
            is_ipv4_q <= is_ipv4_d; is_arp_q <= is_arp_d; is_llc_q <= is_llc_d;
            frame_done_q <= frame_done_d; frame_good_q <= frame_good_d;
            err_crc_q <= err_crc_d; err_len_q <= err_len_d; err_phy_q <= err_phy_d;
            busy_q <= rx_dv;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign m_last     = m_last_q;
    assign hdr_valid  = hdr_valid_q;
    assign sa         = sa_q;
    assign ether_type = ether_type_q;
    assign vlan_valid = vlan_valid_q;
    assign vlan_id    = vlan_id_q;
    assign is_ipv4    = is_ipv4_q;
    assign is_arp     = is_arp_q;
    assign is_llc     = is_llc_q;
    assign frame_done = frame_done_q;
    assign frame_good = frame_good_q;
    assign err_crc    = err_crc_q;
    assign err_len    = err_len_q;
    assign err_phy    = err_phy_q;
    assign busy       = busy_q;

endmodule
